// File: rtl/bp_be_fp_wb_arbiter.sv
// FP register-file writeback arbiter: picks one of FMA / FDIV / load per cycle,
// registers the write, tracks pending destinations and accumulates fflags.
module bp_be_fp_wb_arbiter #(
  parameter int reg_addr_width_p = 5,
  parameter int dword_width_p    = 64,
  parameter int starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        issue_v_i,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        flush_i,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  input  logic [reg_addr_width_p-1:0] rs3_addr_i,
  output logic                        rs1_busy_o,
  output logic                        rs2_busy_o,
  output logic                        rs3_busy_o,
  input  logic                        fma_v_i,
  input  logic [reg_addr_width_p-1:0] fma_rd_i,
  input  logic [dword_width_p-1:0]    fma_data_i,
  input  logic [4:0]                  fma_fflags_i,
  input  logic                        fdiv_v_i,
  output logic                        fdiv_ready_o,
  input  logic [reg_addr_width_p-1:0] fdiv_rd_i,
  input  logic [dword_width_p-1:0]    fdiv_data_i,
  input  logic [4:0]                  fdiv_fflags_i,
  input  logic                        ld_v_i,
  output logic                        ld_ready_o,
  input  logic [reg_addr_width_p-1:0] ld_rd_i,
  input  logic [dword_width_p-1:0]    ld_data_i,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [dword_width_p-1:0]    rd_data_o,
  output logic [4:0]                  fflags_o,
  input  logic                        fflags_clr_i
);

  localparam int num_regs_lp = 1 << reg_addr_width_p;
  localparam int cnt_w_lp    = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] starve_limit_lp = cnt_w_lp'(starve_limit_p);

  logic [cnt_w_lp-1:0]         starve_cnt_r, starve_cnt_nxt_s;
  logic                        starved_s;
  logic                        fdiv_grant_s, ld_grant_s, any_grant_s;
  logic [reg_addr_width_p-1:0] win_rd_s;
  logic [dword_width_p-1:0]    win_data_s;
  logic [4:0]                  win_fflags_s;
  logic [num_regs_lp-1:0]      pending_r, pending_nxt_s;
  logic                        rd_w_v_r;
  logic [reg_addr_width_p-1:0] rd_addr_r;
  logic [dword_width_p-1:0]    rd_data_r;
  logic [4:0]                  fflags_r;

  // FMA never stalls; once FDIV has been blocked long enough it outranks loads.
  assign starved_s    = (starve_cnt_r == starve_limit_lp);
  assign ld_ready_o   = ~fma_v_i & ~(starved_s & fdiv_v_i);
  assign fdiv_ready_o = ~fma_v_i & (starved_s | ~ld_v_i);
  assign fdiv_grant_s = fdiv_v_i & fdiv_ready_o;
  assign ld_grant_s   = ld_v_i & ld_ready_o;
  assign any_grant_s  = fma_v_i | fdiv_grant_s | ld_grant_s;

  // winner selection
  always_comb begin
    win_rd_s     = {reg_addr_width_p{1'b0}};
    win_data_s   = {dword_width_p{1'b0}};
    win_fflags_s = 5'b00000;
    if (fma_v_i) begin
      win_rd_s     = fma_rd_i;
      win_data_s   = fma_data_i;
      win_fflags_s = fma_fflags_i;
    end else if (fdiv_grant_s) begin
      win_rd_s     = fdiv_rd_i;
      win_data_s   = fdiv_data_i;
      win_fflags_s = fdiv_fflags_i;
    end else if (ld_grant_s) begin
      win_rd_s     = ld_rd_i;
      win_data_s   = ld_data_i;
      win_fflags_s = 5'b00000;
    end else begin
      win_fflags_s = 5'b00000;
    end
  end

  // starve counter next state
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!fdiv_v_i || fdiv_grant_s) begin
      starve_cnt_nxt_s = {cnt_w_lp{1'b0}};
    end else if (starve_cnt_r != starve_limit_lp) begin
      starve_cnt_nxt_s = starve_cnt_r + cnt_w_lp'(1);
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // scoreboard next state: issue beats a same-cycle retire, flush beats everything
  always_comb begin
    pending_nxt_s = pending_r;
    if (rd_w_v_r) begin
      pending_nxt_s[rd_addr_r] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_v_i) begin
      pending_nxt_s[issue_rd_i] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (flush_i) begin
      pending_nxt_s = {num_regs_lp{1'b0}};
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= {cnt_w_lp{1'b0}};
      pending_r    <= {num_regs_lp{1'b0}};
      rd_w_v_r     <= 1'b0;
      rd_addr_r    <= {reg_addr_width_p{1'b0}};
      rd_data_r    <= {dword_width_p{1'b0}};
      fflags_r     <= 5'b00000;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      pending_r    <= pending_nxt_s;
      rd_w_v_r     <= any_grant_s;
      if (any_grant_s) begin
        rd_addr_r <= win_rd_s;
        rd_data_r <= win_data_s;
      end
      fflags_r <= (fflags_clr_i ? 5'b00000 : fflags_r) | win_fflags_s;
    end
  end

  assign rd_w_v_o  = rd_w_v_r;
  assign rd_addr_o = rd_addr_r;
  assign rd_data_o = rd_data_r;
  assign fflags_o  = fflags_r;

  // the write in flight this cycle is forwarded by the regfile, so it is not a hazard
  assign rs1_busy_o = pending_r[rs1_addr_i] & ~(rd_w_v_r & (rd_addr_r == rs1_addr_i));
  assign rs2_busy_o = pending_r[rs2_addr_i] & ~(rd_w_v_r & (rd_addr_r == rs2_addr_i));
  assign rs3_busy_o = pending_r[rs3_addr_i] & ~(rd_w_v_r & (rd_addr_r == rs3_addr_i));

endmodule

// File: tb/tb_bp_be_fp_wb_arbiter.sv
// Directed bench for bp_be_fp_wb_arbiter: expected regfile writes go into a
// queue that a monitor drains; control outputs are compared against constants.
module tb_bp_be_fp_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_v = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0, rs3_addr = 5'd0;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        fma_v = 1'b0;
  logic [4:0]  fma_rd = 5'd0;
  logic [63:0] fma_data = 64'd0;
  logic [4:0]  fma_fflags = 5'd0;
  logic        fdiv_v = 1'b0, fdiv_ready;
  logic [4:0]  fdiv_rd = 5'd0;
  logic [63:0] fdiv_data = 64'd0;
  logic [4:0]  fdiv_fflags = 5'd0;
  logic        ld_v = 1'b0, ld_ready;
  logic [4:0]  ld_rd = 5'd0;
  logic [63:0] ld_data = 64'd0;
  logic        rd_w_v;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  bp_be_fp_wb_arbiter #(.reg_addr_width_p(5), .dword_width_p(64), .starve_limit_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .issue_v_i(issue_v), .issue_rd_i(issue_rd), .flush_i(flush),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs3_addr_i(rs3_addr),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .rs3_busy_o(rs3_busy),
    .fma_v_i(fma_v), .fma_rd_i(fma_rd), .fma_data_i(fma_data), .fma_fflags_i(fma_fflags),
    .fdiv_v_i(fdiv_v), .fdiv_ready_o(fdiv_ready), .fdiv_rd_i(fdiv_rd),
    .fdiv_data_i(fdiv_data), .fdiv_fflags_i(fdiv_fflags),
    .ld_v_i(ld_v), .ld_ready_o(ld_ready), .ld_rd_i(ld_rd), .ld_data_i(ld_data),
    .rd_w_v_o(rd_w_v), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset_n && rd_w_v) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got f%0d=%0h expected no write at %0t", rd_addr, rd_data, $time);
          end else begin
            wb_t e;
            e = exp_q.pop_front();
            if (rd_addr !== e.addr || rd_data !== e.data) begin
              errors++;
              $display("FAIL wb_data: got f%0d=%0h expected f%0d=%0h at %0t",
                       rd_addr, rd_data, e.addr, e.data, $time);
            end
          end
        end
      end
    join_none

    // reset state
    #12;
    chk("rst_wv", rd_w_v, 64'd0);
    chk("rst_fflags", fflags, 64'd0);
    chk("rst_busy", rs1_busy, 64'd0);
    chk("rst_ld_ready", ld_ready, 64'd1);
    chk("rst_fdiv_ready", fdiv_ready, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // FMA and load collide: FMA first, load next cycle
    step();
    fma_v = 1'b1; fma_rd = 5'd3; fma_data = 64'hA; fma_fflags = 5'd0;
    ld_v = 1'b1; ld_rd = 5'd4; ld_data = 64'h44;
    push(5'd3, 64'hA);
    #1;
    chk("collide_ld_ready", ld_ready, 64'd0);
    chk("collide_fdiv_ready", fdiv_ready, 64'd0);
    step();
    fma_v = 1'b0;
    push(5'd4, 64'h44);
    #1;
    chk("ld_after_fma_ready", ld_ready, 64'd1);
    step();
    ld_v = 1'b0;

    // FDIV starved by back-to-back loads
    step();
    fdiv_v = 1'b1; fdiv_rd = 5'd10; fdiv_data = 64'hD1; fdiv_fflags = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      ld_v = 1'b1; ld_rd = 5'(11 + i); ld_data = 64'h100 + 64'(i);
      #1;
      chk("starve_fdiv_ready_lo", fdiv_ready, 64'd0);
      chk("starve_ld_ready_hi", ld_ready, 64'd1);
      push(ld_rd, ld_data);
      step();
    end
    ld_rd = 5'd15; ld_data = 64'h104;
    #1;
    chk("starved_fdiv_ready", fdiv_ready, 64'd1);
    chk("starved_ld_ready", ld_ready, 64'd0);
    push(5'd10, 64'hD1);
    step();
    fdiv_rd = 5'd12; fdiv_data = 64'hD2; fdiv_fflags = 5'd0;
    #1;
    chk("cnt_cleared_fdiv_ready", fdiv_ready, 64'd0);
    chk("cnt_cleared_ld_ready", ld_ready, 64'd1);
    push(5'd15, 64'h104);
    step();
    fdiv_v = 1'b0; ld_v = 1'b0;
    step();
    chk("fflags_fdiv", fflags, 64'b00001);

    // fflags accumulate and clear
    fma_v = 1'b1; fma_rd = 5'd2; fma_data = 64'hF2; fma_fflags = 5'b10000;
    push(5'd2, 64'hF2);
    step();
    chk("fflags_accum", fflags, 64'b10001);
    fma_data = 64'hF3; fma_fflags = 5'b00100; fflags_clr = 1'b1;
    push(5'd2, 64'hF3);
    step();
    chk("fflags_clr_accum", fflags, 64'b00100);
    fma_v = 1'b0; fma_fflags = 5'd0;
    step();
    chk("fflags_clr_idle", fflags, 64'd0);
    fflags_clr = 1'b0;

    // scoreboard busy, forwarding and set-beats-clear
    issue_v = 1'b1; issue_rd = 5'd7;
    step();
    issue_v = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd8;
    #1;
    chk("busy_after_issue", rs1_busy, 64'd1);
    chk("busy_other_reg", rs2_busy, 64'd0);
    fma_v = 1'b1; fma_rd = 5'd7; fma_data = 64'h77;
    push(5'd7, 64'h77);
    step();
    fma_v = 1'b0;
    issue_v = 1'b1; issue_rd = 5'd7;
    #1;
    chk("busy_forwarded", rs1_busy, 64'd0);
    step();
    issue_v = 1'b0;
    #1;
    chk("busy_reissue_wins", rs1_busy, 64'd1);
    fma_v = 1'b1; fma_rd = 5'd7; fma_data = 64'h78;
    push(5'd7, 64'h78);
    step();
    fma_v = 1'b0;
    step();
    chk("busy_retired", rs1_busy, 64'd0);

    // flush clears everything including a same-cycle issue
    issue_v = 1'b1; issue_rd = 5'd1;
    step();
    issue_rd = 5'd2;
    step();
    issue_v = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2; rs3_addr = 5'd9;
    #1;
    chk("pre_flush_busy1", rs1_busy, 64'd1);
    chk("pre_flush_busy2", rs2_busy, 64'd1);
    chk("pre_flush_busy3", rs3_busy, 64'd0);
    flush = 1'b1; issue_v = 1'b1; issue_rd = 5'd9;
    step();
    flush = 1'b0; issue_v = 1'b0;
    #1;
    chk("flush_busy1", rs1_busy, 64'd0);
    chk("flush_busy2", rs2_busy, 64'd0);
    chk("flush_busy3", rs3_busy, 64'd0);
    fma_v = 1'b1; fma_rd = 5'd1; fma_data = 64'h11;
    push(5'd1, 64'h11);
    step();
    fma_v = 1'b0;

    // async reset mid-stream with every register pending
    fma_v = 1'b1; fma_rd = 5'd0; fma_data = 64'h0F; fma_fflags = 5'b00010;
    push(5'd0, 64'h0F);
    step();
    fma_v = 1'b0; fma_fflags = 5'd0;
    step();
    chk("fflags_pre_reset", fflags, 64'b00010);
    for (int i = 0; i < 32; i++) begin
      issue_v = 1'b1; issue_rd = 5'(i);
      step();
    end
    issue_v = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd31; rs3_addr = 5'd17;
    #1;
    chk("all_pending1", rs1_busy, 64'd1);
    chk("all_pending2", rs2_busy, 64'd1);
    chk("all_pending3", rs3_busy, 64'd1);
    fma_v = 1'b1; fma_rd = 5'd5; fma_data = 64'h55;
    step();
    fma_v = 1'b0;
    chk("pre_reset_wv", rd_w_v, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_wv", rd_w_v, 64'd0);
    chk("async_rst_addr", rd_addr, 64'd0);
    chk("async_rst_data", rd_data, 64'd0);
    chk("async_rst_fflags", fflags, 64'd0);
    chk("async_rst_busy1", rs1_busy, 64'd0);
    chk("async_rst_busy2", rs2_busy, 64'd0);
    chk("async_rst_busy3", rs3_busy, 64'd0);
    step();
    step();
    chk("wb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
